// File: rtl/spi_register_controller_pkg.sv
// Shared types and constants for the SPI register-access command controller.
package spi_register_controller_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WRITE_DATA,
    READ_DATA,
    DISCARD
  } state_e;

  localparam int unsigned CMD_WRITE_BIT   = 7;
  localparam int unsigned CMD_AUTOINC_BIT = 6;
  localparam int unsigned CMD_RSVD_MSB    = 5;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

  // Reserved command bits must be zero for a frame to be accepted.
  function automatic logic cmd_is_legal(input logic [7:0] cmd);
    return cmd[CMD_RSVD_MSB:0] == '0;
  endfunction

endpackage

// File: rtl/spi_register_controller_frame_timeout.sv
// Inactivity counter: counts while enabled, clears on activity, flags the final count.
module frame_timeout #(
  parameter int unsigned LIMIT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam int unsigned CW = $clog2(LIMIT);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] count;
  logic [CW-1:0] count_next;

  // Saturate at the last count so a stalled frame cannot wrap back to zero.
  always_comb begin
    count_next = count;
    if (clear || !enable) begin
      count_next = '0;
    end else if (count != LAST) begin
      count_next = count + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      expired <= 1'b0;
    end else begin
      count   <= count_next;
      expired <= (count_next == LAST);
    end
  end

endmodule

// File: rtl/spi_register_controller.sv
// Decodes framed register-access commands from the SPI byte stream and
// drives the register-file port plus the next MISO byte.
module spi_register_controller
  import spi_register_controller_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = 7,
  parameter int unsigned IDLE_TIMEOUT = 1024,
  parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [7:0]            tx_data,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [7:0]            reg_wdata,
  output logic                  reg_we,
  output logic                  reg_re,
  input  logic [7:0]            reg_rdata,
  output logic                  busy,
  output logic                  frame_error
);

  state_e state;
  state_e state_next;

  logic                  cmd_wr;
  logic                  cmd_ai;
  logic                  cmd_wr_next;
  logic                  cmd_ai_next;
  logic [7:0]            tx_next;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic [7:0]            wdata_next;
  logic                  we_next;
  logic                  re_next;
  logic                  busy_next;
  logic                  ferr_next;
  logic                  expired;

  frame_timeout #(
    .LIMIT (IDLE_TIMEOUT)
  ) u_frame_timeout (
    .clk     (clk),
    .rst_n   (rst),
    .enable  (state != IDLE),
    .clear   (rx_valid),
    .expired (expired)
  );

  always_comb begin
    state_next  = state;
    cmd_wr_next = cmd_wr;
    cmd_ai_next = cmd_ai;
    tx_next     = tx_data;
    addr_next   = reg_addr;
    wdata_next  = reg_wdata;
    we_next     = 1'b0;
    re_next     = 1'b0;
    ferr_next   = 1'b0;

    // Write auto-increment takes effect once the strobe has been issued.
    if (reg_we && cmd_ai) begin
      addr_next = reg_addr + ADDR_WIDTH'(1);
    end

    case (state)
      IDLE: begin
        tx_next = SYNC_BYTE;
        if (rx_valid) begin
          tx_next = 8'h00;
          if (cmd_is_legal(rx_data)) begin
            state_next  = ADDR;
            cmd_wr_next = rx_data[CMD_WRITE_BIT];
            cmd_ai_next = rx_data[CMD_AUTOINC_BIT];
          end else begin
            state_next = DISCARD;
            ferr_next  = 1'b1;
          end
        end
      end

      ADDR: begin
        if (rx_valid) begin
          addr_next = ADDR_WIDTH'(rx_data);
          if (cmd_wr) begin
            state_next = WRITE_DATA;
          end else begin
            state_next = READ_DATA;
            re_next    = 1'b1;
          end
        end
      end

      WRITE_DATA: begin
        if (rx_valid) begin
          wdata_next = rx_data;
          we_next    = 1'b1;
        end
      end

      READ_DATA: begin
        if (reg_re) begin
          tx_next = reg_rdata;
        end
        // Each clocked-out byte triggers the prefetch for the following one.
        if (rx_valid) begin
          if (cmd_ai) begin
            addr_next = reg_addr + ADDR_WIDTH'(1);
          end
          re_next = 1'b1;
        end
      end

      DISCARD: begin
        tx_next = 8'h00;
      end

      default: begin
        state_next = IDLE;
        tx_next    = SYNC_BYTE;
      end
    endcase

    // A byte arriving on the expiry cycle keeps the frame alive.
    if ((state != IDLE) && expired && !rx_valid) begin
      state_next = IDLE;
      tx_next    = SYNC_BYTE;
      we_next    = 1'b0;
      re_next    = 1'b0;
    end

    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cmd_wr      <= 1'b0;
      cmd_ai      <= 1'b0;
      tx_data     <= SYNC_BYTE;
      reg_addr    <= '0;
      reg_wdata   <= '0;
      reg_we      <= 1'b0;
      reg_re      <= 1'b0;
      busy        <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      state       <= state_next;
      cmd_wr      <= cmd_wr_next;
      cmd_ai      <= cmd_ai_next;
      tx_data     <= tx_next;
      reg_addr    <= addr_next;
      reg_wdata   <= wdata_next;
      reg_we      <= we_next;
      reg_re      <= re_next;
      busy        <= busy_next;
      frame_error <= ferr_next;
    end
  end

endmodule

// File: tb/tb_spi_register_controller.sv
// Scoreboard bench for spi_register_controller with a small behavioural register file.
module tb_spi_register_controller;

  localparam int unsigned AW  = 7;
  localparam int unsigned TO  = 64;
  localparam int unsigned GAP = 9;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic [7:0]    tx_data;
  logic [AW-1:0] reg_addr;
  logic [7:0]    reg_wdata;
  logic          reg_we;
  logic          reg_re;
  logic [7:0]    reg_rdata;
  logic          busy;
  logic          frame_error;

  logic [7:0] mem [0:(1 << AW) - 1];
  exp_t       exp_q[$];
  int         total = 0;
  int         bad   = 0;

  spi_register_controller #(
    .ADDR_WIDTH   (AW),
    .IDLE_TIMEOUT (TO),
    .SYNC_BYTE    (8'hA5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .tx_data     (tx_data),
    .reg_addr    (reg_addr),
    .reg_wdata   (reg_wdata),
    .reg_we      (reg_we),
    .reg_re      (reg_re),
    .reg_rdata   (reg_rdata),
    .busy        (busy),
    .frame_error (frame_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (reg_we) mem[reg_addr] <= reg_wdata;
  assign reg_rdata = mem[reg_addr];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic push_exp(input logic wr, input logic [AW-1:0] addr, input logic [7:0] data);
    exp_t e;
    e.wr = wr; e.addr = addr; e.data = data;
    exp_q.push_back(e);
  endtask

  // Drive one byte, then scan the following gap for strobes against the scoreboard.
  task automatic send_byte(input logic [7:0] b, output logic [7:0] tx_seen,
                           output logic busy_seen, output int ferr_cnt);
    exp_t e;
    ferr_cnt = 0;
    @(posedge clk); #1;
    rx_data = b; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    for (int i = 0; i < int'(GAP); i++) begin
      @(negedge clk);
      if (frame_error) ferr_cnt++;
      if (reg_we || reg_re) begin
        total++;
        if (reg_we && reg_re) begin
          bad++;
          $display("FAIL strobe_overlap: we=%b re=%b, required never both", reg_we, reg_re);
        end else if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_strobe: we=%b re=%b addr=%h after byte %h, required none",
                   reg_we, reg_re, reg_addr, b);
        end else begin
          e = exp_q.pop_front();
          if (e.wr !== reg_we || e.addr !== reg_addr || (e.wr && e.data !== reg_wdata) || i != 0) begin
            bad++;
            $display("FAIL strobe: got we=%b addr=%h data=%h at cycle+%0d, required we=%b addr=%h data=%h at cycle+1",
                     reg_we, reg_addr, reg_wdata, i + 1, e.wr, e.addr, e.data);
          end
        end
      end
    end
    tx_seen   = tx_data;
    busy_seen = busy;
  endtask

  task automatic wait_frame_end();
    for (int i = 0; i < int'(TO) + 40; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (tx_data !== 8'hA5) begin bad++; $display("FAIL reset_tx: got %h required a5", tx_data); end
    total++; if (reg_addr !== '0) begin bad++; $display("FAIL reset_addr: got %h required 00", reg_addr); end
    total++; if (reg_wdata !== 8'h00) begin bad++; $display("FAIL reset_wdata: got %h required 00", reg_wdata); end
    total++; if (reg_we !== 1'b0 || reg_re !== 1'b0) begin bad++; $display("FAIL reset_strobes: we=%b re=%b required 0 0", reg_we, reg_re); end
    total++; if (busy !== 1'b0 || frame_error !== 1'b0) begin bad++; $display("FAIL reset_flags: busy=%b ferr=%b required 0 0", busy, frame_error); end
    rst = 1'b1;
  endtask

  task automatic test_write_burst();
    logic [7:0] tx; logic bz; int fe;
    send_byte(8'hC0, tx, bz, fe);
    total++; if (bz !== 1'b1 || tx !== 8'h00) begin bad++; $display("FAIL wr_cmd_state: busy=%b tx=%h required 1 00", bz, tx); end
    send_byte(8'h10, tx, bz, fe);
    push_exp(1'b1, 7'h10, 8'h11); send_byte(8'h11, tx, bz, fe);
    push_exp(1'b1, 7'h11, 8'h22); send_byte(8'h22, tx, bz, fe);
    total++; if (tx !== 8'h00) begin bad++; $display("FAIL wr_data_tx: got %h required 00", tx); end
    wait_frame_end();
    total++; if (busy !== 1'b0 || tx_data !== 8'hA5) begin bad++; $display("FAIL wr_timeout: busy=%b tx=%h required 0 a5", busy, tx_data); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL wr_missing: %0d strobes outstanding, required 0", exp_q.size()); end
  endtask

  task automatic test_read_burst();
    logic [7:0] tx; logic bz; int fe;
    send_byte(8'hC0, tx, bz, fe); send_byte(8'h05, tx, bz, fe);
    push_exp(1'b1, 7'h05, 8'h5A); send_byte(8'h5A, tx, bz, fe);
    push_exp(1'b1, 7'h06, 8'h3C); send_byte(8'h3C, tx, bz, fe);
    wait_frame_end();
    send_byte(8'h40, tx, bz, fe);
    push_exp(1'b0, 7'h05, 8'h00); send_byte(8'h05, tx, bz, fe);
    total++; if (tx !== 8'h5A) begin bad++; $display("FAIL rd_first: tx=%h required 5a", tx); end
    push_exp(1'b0, 7'h06, 8'h00); send_byte(8'hFF, tx, bz, fe);
    total++; if (tx !== 8'h3C) begin bad++; $display("FAIL rd_second: tx=%h required 3c", tx); end
    wait_frame_end();
    total++; if (exp_q.size() != 0 || tx_data !== 8'hA5) begin bad++; $display("FAIL rd_end: outstanding=%0d tx=%h required 0 a5", exp_q.size(), tx_data); end
  endtask

  task automatic test_no_autoinc();
    logic [7:0] tx; logic bz; int fe;
    send_byte(8'h80, tx, bz, fe); send_byte(8'h07, tx, bz, fe);
    push_exp(1'b1, 7'h07, 8'h77); send_byte(8'h77, tx, bz, fe);
    push_exp(1'b1, 7'h07, 8'h78); send_byte(8'h78, tx, bz, fe);
    wait_frame_end();
    send_byte(8'h00, tx, bz, fe);
    push_exp(1'b0, 7'h07, 8'h00); send_byte(8'h07, tx, bz, fe);
    total++; if (tx !== 8'h78) begin bad++; $display("FAIL noai_rd0: tx=%h required 78", tx); end
    for (int k = 0; k < 2; k++) begin
      push_exp(1'b0, 7'h07, 8'h00); send_byte(8'hAA, tx, bz, fe);
      total++; if (tx !== 8'h78) begin bad++; $display("FAIL noai_rd%0d: tx=%h required 78", k + 1, tx); end
    end
    wait_frame_end();
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL noai_missing: %0d outstanding, required 0", exp_q.size()); end
  endtask

  task automatic test_wrap();
    logic [7:0] tx; logic bz; int fe;
    send_byte(8'hC0, tx, bz, fe); send_byte(8'h7F, tx, bz, fe);
    push_exp(1'b1, 7'h7F, 8'hD1); send_byte(8'hD1, tx, bz, fe);
    push_exp(1'b1, 7'h00, 8'hD2); send_byte(8'hD2, tx, bz, fe);
    wait_frame_end();
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL wrap_missing: %0d outstanding, required 0", exp_q.size()); end
  endtask

  task automatic test_illegal();
    logic [7:0] tx; logic bz; int fe; int fe_rest;
    send_byte(8'h81, tx, bz, fe);
    total++; if (fe != 1 || bz !== 1'b1) begin bad++; $display("FAIL illegal_err: pulses=%0d busy=%b required 1 1", fe, bz); end
    fe_rest = 0;
    send_byte(8'hC0, tx, bz, fe); fe_rest += fe;
    send_byte(8'h10, tx, bz, fe); fe_rest += fe;
    send_byte(8'h22, tx, bz, fe); fe_rest += fe;
    total++; if (fe_rest != 0) begin bad++; $display("FAIL discard_err: pulses=%0d required 0", fe_rest); end
    repeat (TO - 15) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL discard_early_exit: busy=%b required 1", busy); end
    wait_frame_end();
    total++; if (busy !== 1'b0 || tx_data !== 8'hA5) begin bad++; $display("FAIL discard_timeout: busy=%b tx=%h required 0 a5", busy, tx_data); end
  endtask

  // Address byte lands on the exact cycle the inactivity count expires.
  task automatic test_timeout_race();
    logic [7:0] tx; logic bz; int fe;
    send_byte(8'hC0, tx, bz, fe);
    repeat (TO - 10) @(posedge clk);
    send_byte(8'h30, tx, bz, fe);
    total++; if (bz !== 1'b1 || tx !== 8'h00) begin bad++; $display("FAIL race_keep: busy=%b tx=%h required 1 00", bz, tx); end
    push_exp(1'b1, 7'h30, 8'h55); send_byte(8'h55, tx, bz, fe);
    wait_frame_end();
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL race_missing: %0d outstanding, required 0", exp_q.size()); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] tx; logic bz; int fe; int strobes;
    send_byte(8'hC0, tx, bz, fe); send_byte(8'h20, tx, bz, fe);
    @(posedge clk); #3 rst = 1'b0; #1;
    total++; if (busy !== 1'b0 || tx_data !== 8'hA5 || reg_addr !== '0 || reg_wdata !== 8'h00)
      begin bad++; $display("FAIL rst_async: busy=%b tx=%h addr=%h wdata=%h required 0 a5 00 00", busy, tx_data, reg_addr, reg_wdata); end
    strobes = 0;
    repeat (3) begin @(negedge clk); if (reg_we || reg_re) strobes++; end
    rst = 1'b1;
    repeat (3) begin @(negedge clk); if (reg_we || reg_re) strobes++; end
    total++; if (strobes != 0) begin bad++; $display("FAIL rst_strobe: %0d strobes, required 0", strobes); end
    send_byte(8'hC0, tx, bz, fe); send_byte(8'h21, tx, bz, fe);
    push_exp(1'b1, 7'h21, 8'h44); send_byte(8'h44, tx, bz, fe);
    wait_frame_end();
    total++; if (exp_q.size() != 0 || busy !== 1'b0) begin bad++; $display("FAIL rst_next_frame: outstanding=%0d busy=%b required 0 0", exp_q.size(), busy); end
  endtask

  initial begin
    test_reset();
    test_write_burst();
    test_read_burst();
    test_no_autoinc();
    test_wrap();
    test_illegal();
    test_timeout_race();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_register_controller.md
# spi_register_controller

Byte-level command controller sitting behind the SPI slave reader. Interprets the received byte stream as framed register-access commands, drives a simple synchronous register-file port, and supplies the next byte to shift out on MISO. Frames are delimited by an inactivity timeout, since the SPI link carries no chip-select.

## Interface
- `ADDR_WIDTH`, default 7: register address width; addresses wrap modulo 2^ADDR_WIDTH.
- `IDLE_TIMEOUT`, default 1024: `clk` cycles without `rx_valid` that terminate a frame.
- `SYNC_BYTE`, default 8'hA5: byte presented on `tx_data` while idle.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `rx_data`  in  8  byte from the SPI reader; valid when `rx_valid` is high.
- `rx_valid`  in  1  one-cycle pulse per completed received byte.
- `tx_data`  out  8  byte for the reader to shift out on MISO; reader samples it at the start of each byte.
- `reg_addr`  out  ADDR_WIDTH  register address.
- `reg_wdata`  out  8  write data.
- `reg_we`  out  1  one-cycle write strobe.
- `reg_re`  out  1  one-cycle read strobe.
- `reg_rdata`  in  8  read data, valid the cycle after `reg_re`.
- `busy`  out  1  high whenever state is not IDLE.
- `frame_error`  out  1  one-cycle pulse on an illegal command byte.

## Operation
- Frame: command byte, address byte, then zero or more data bytes; ended only by timeout or reset.
- Command byte: bit7 = 1 write, 0 read; bit6 = auto-increment; bits[5:0] must be 0. A nonzero bits[5:0] pulses `frame_error` and enters DISCARD.
- States: IDLE -> (rx_valid, legal cmd) ADDR; IDLE -> (rx_valid, illegal cmd) DISCARD; ADDR -> (rx_valid) WRITE_DATA or READ_DATA; any non-IDLE -> IDLE on timeout.
- ADDR: latch `rx_data[ADDR_WIDTH-1:0]` into `reg_addr`; upper bits ignored. If read, issue prefetch (`reg_re`) on the next cycle.
- WRITE_DATA: each `rx_valid` -> `reg_wdata` = `rx_data`, `reg_we` pulse the next cycle with the current `reg_addr`; after the strobe, `reg_addr` increments if auto-increment is set.
- READ_DATA: the prefetched value is loaded into `tx_data` the cycle after `reg_re`. Each `rx_valid` (content ignored) advances `reg_addr` if auto-increment is set, then issues a new `reg_re`; without auto-increment the same address is re-read.
- DISCARD: ignore all bytes; no strobes.
- `tx_data`: `SYNC_BYTE` in IDLE; 8'h00 while in ADDR and WRITE_DATA; read data in READ_DATA.
- Timeout: a counter clears on every `rx_valid` and counts in non-IDLE states. On reaching `IDLE_TIMEOUT`-1 the controller returns to IDLE, and `tx_data` returns to `SYNC_BYTE` on that same transition. If `rx_valid` coincides with expiry, `rx_valid` wins: the counter clears and the byte is processed.
- Address wrap: all-ones + 1 -> 0, no flag.

## Timing
- Reset values: state IDLE, `tx_data` = `SYNC_BYTE`, `reg_addr` = 0, `reg_wdata` = 0, `reg_we` = 0, `reg_re` = 0, `busy` = 0, `frame_error` = 0, timeout counter = 0.
- Reset is asynchronous. Reset mid-frame aborts without any strobe.
- Write latency: `reg_we` at T+1 for `rx_valid` at T.
- Read latency: `reg_re` at T+1, `tx_data` valid at T+2 for `rx_valid` at T.
- `reg_we` and `reg_re` are never high together.
- Consecutive `rx_valid` pulses are guaranteed at least 8 `clk` cycles apart. `tx_data` is stable within 3 cycles of any `rx_valid`.

## Structure
- Shared package holds the state enum (IDLE, ADDR, WRITE_DATA, READ_DATA, DISCARD), the command bit positions, and the `SYNC_BYTE` default.
- One natural sub-module: `frame_timeout`, a loadable inactivity counter with `clear` and `expired` signals.

## Test plan
- Write burst: rx 8'hC0, 8'h10, 8'h11, 8'h22 -> `reg_we` at addr 0x10 with data 0x11, then at addr 0x11 with data 0x22.
- Read burst: rx 8'h40, 8'h05; regfile returns 0x5A@05 and 0x3C@06 -> `tx_data` = 0x5A after the address byte, 0x3C after the next byte.
- No auto-increment read: rx 8'h00, 8'h07, then two dummy bytes -> `reg_re` three times, all at addr 0x07.
- Wrap: write cmd 8'hC0 to addr 0x7F with 2 data bytes -> strobes at 0x7F, then 0x00.
- Illegal command: rx 8'h81 -> `frame_error` pulses; following bytes produce no strobes; after `IDLE_TIMEOUT` cycles of silence `busy` = 0 and `tx_data` = 0xA5.
- Reset mid-frame: assert `rst` low after the address byte of a write -> no `reg_we`; all outputs at their reset values; next frame decodes normally.
